// File: rtl/spi_reg_pkg.sv
// Shared types and command-word field helpers for the SPI register slave.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_t;

  // Cycles after reset before the synchronizer outputs reflect the real pins.
  localparam int SYNC_WARM = 3;

  // The write flag is the MSB of the command word.
  function automatic int wr_flag_idx(input int data_w);
    return data_w - 1;
  endfunction

  // Everything below the write flag is address.
  function automatic int addr_width(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, with edge detect in the clk domain.
module spi_sync #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make each flop take its neighbour's old value, so this is a real 3-stage chain.
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave exposing a bank of writable output registers and read-only input registers.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 2,
  parameter int N_IN   = 2,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ss_l,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  output logic [N_OUT*DATA_W-1:0] out_regs,
  input  logic [N_IN*DATA_W-1:0]  in_regs,
  output logic [N_OUT-1:0]        wr_strobe,
  output logic                    frame_err
);

  localparam int WR_IDX = wr_flag_idx(DATA_W);
  localparam int ADDR_W = addr_width(DATA_W);
  localparam int CNT_W  = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic ss_q, ss_rise, ss_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync #(.RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(ss_l), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync #(.RESET_VAL(CPOL != 0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_q, mosi_rise, mosi_fall};

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-2:0]   shreg_in;
  logic [DATA_W-1:0]   shreg_out;
  logic                cmd_wr;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   out_q [N_OUT];
  logic [1:0]          warm_cnt;
  logic                armed;

  // The word completed by the current sample: bits gathered so far plus this one.
  logic [DATA_W-1:0]   word;
  logic [ADDR_W-1:0]   word_addr;
  assign word      = {shreg_in, mosi_q};
  assign word_addr = word[ADDR_W-1:0];

  logic [DATA_W-1:0]   rd_val;

  always_comb begin
    // NOTE: default first so every path assigns rd_val and no latch is inferred.
    rd_val = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (int'(word_addr) == i) rd_val = out_q[i];
    end
    for (int j = 0; j < N_IN; j++) begin
      if (int'(word_addr) == N_OUT + j) rd_val = in_regs[j*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg_in  <= '0;
      shreg_out <= '0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      // NOTE: the register bank is a handful of flops driving outputs, not a RAM, so it is reset like any other state.
      for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      warm_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      miso_oe   <= ~ss_q;

      // Ignore a select that was already low when reset released; wait for it to go high first.
      if (warm_cnt != 2'(SYNC_WARM)) warm_cnt <= warm_cnt + 2'd1;
      else if (ss_q) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          if (ss_fall && armed) begin
            state    <= ST_CMD;
            bit_cnt  <= '0;
            shreg_in <= '0;
          end
        end

        ST_CMD: begin
          miso <= 1'b0;
          if (ss_rise) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (sample_edge) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              shreg_in  <= '0;
              cmd_wr    <= word[WR_IDX];
              cmd_addr  <= word_addr;
              shreg_out <= word[WR_IDX] ? '0 : rd_val;
              state     <= ST_DATA;
            end else begin
              bit_cnt  <= bit_cnt + CNT_W'(1);
              shreg_in <= word[DATA_W-2:0];
            end
          end
        end

        ST_DATA: begin
          if (sample_edge && bit_cnt == LAST_BIT) begin
            // A final sample coinciding with deselect still completes the frame.
            if (cmd_wr) begin
              for (int i = 0; i < N_OUT; i++) begin
                if (int'(cmd_addr) == i) begin
                  out_q[i]     <= word;
                  wr_strobe[i] <= 1'b1;
                end
              end
            end
            bit_cnt <= '0;
            miso    <= 1'b0;
            state   <= ss_rise ? ST_IDLE : ST_DONE;
          end else if (ss_rise) begin
            frame_err <= 1'b1;
            miso      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            if (sample_edge) begin
              bit_cnt  <= bit_cnt + CNT_W'(1);
              shreg_in <= word[DATA_W-2:0];
            end
            if (shift_edge) begin
              miso      <= shreg_out[DATA_W-1];
              shreg_out <= {shreg_out[DATA_W-2:0], 1'b0};
            end
          end
        end

        ST_DONE: begin
          miso <= 1'b0;
          if (ss_rise) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_regs[g*DATA_W +: DATA_W] = out_q[g];
  end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter DATA_W, default 8, SPI word width in bits; legal range 4..32.
REQ-002 Parameter N_OUT, default 2, number of writable output registers.
REQ-003 Parameter N_IN, default 2, number of read-only input registers; N_OUT+N_IN SHALL be <= 2^(DATA_W-1).
REQ-004 Parameter CPOL, default 0, SPI clock idle level.
REQ-005 Parameter CPHA, default 0, SPI clock phase (0: sample on leading edge; 1: sample on trailing edge).
REQ-006 clk  input  1  system clock; all state on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 ss_l  input  1  SPI slave select, active low, asynchronous to clk.
REQ-009 sclk  input  1  SPI clock, asynchronous to clk.
REQ-010 mosi  input  1  SPI data in, MSB first.
REQ-011 miso  output  1  SPI data out, MSB first.
REQ-012 miso_oe  output  1  high while ss_l is synchronously low; for an external tristate buffer.
REQ-013 out_regs  output  N_OUT*DATA_W  output register bank; register i occupies bits [i*DATA_W +: DATA_W].
REQ-014 in_regs  input  N_IN*DATA_W  input register bank, same packing; asynchronous to clk.
REQ-015 wr_strobe  output  N_OUT  one-hot, 1-cycle pulse when out_regs[i] is updated.
REQ-016 frame_err  output  1  1-cycle pulse on an aborted frame.

Function
REQ-017 ss_l, sclk and mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected in the clk domain; clk SHALL be at least 8x the sclk frequency.
REQ-018 Sample edge and shift edge:
- Leading edge = the sclk transition away from CPOL.
- Sample edge = leading edge if CPHA=0, else trailing edge.
- Shift edge = the other edge.
REQ-019 A frame SHALL be one command word followed by one data word, each DATA_W bits.
REQ-020 Command word fields: MSB = write flag (1 write, 0 read); bits [DATA_W-2:0] = address.
REQ-021 Address map: 0..N_OUT-1 select out_regs; N_OUT..N_OUT+N_IN-1 select in_regs; all other addresses read 0 and ignore writes.
REQ-022 FSM states: IDLE, CMD, DATA, DONE.
REQ-023 IDLE -> CMD on synchronized ss_l falling; bit counter cleared.
REQ-024 CMD: shift mosi in on each sample edge; after DATA_W sample edges, latch the command and go to DATA.
REQ-025 On entry to DATA, a read SHALL load the shift-out register with the addressed register value.
REQ-026 in_regs SHALL be captured into the shift-out register in one clk cycle as a snapshot.
REQ-027 miso SHALL be 0 during CMD and DONE.
REQ-028 In DATA, miso SHALL present the next bit on each shift edge; the MSB SHALL be presented on the first shift edge after the last command sample edge, in all modes.
REQ-029 DATA: after DATA_W sample edges, a write to a valid out_regs address SHALL update that register one clk after the final sample edge and pulse the matching wr_strobe bit for one cycle; then go to DONE.
REQ-030 DONE: further sclk edges SHALL be ignored; synchronized ss_l rising -> IDLE.
REQ-031 Synchronized ss_l rising in CMD or DATA before DATA_W bits SHALL:
- pulse frame_err for 1 cycle;
- suppress any write;
- return the FSM to IDLE.
REQ-032 ss_l rising on the same clk as the final sample edge SHALL count as complete; the write proceeds and frame_err stays low.
REQ-033 Read of a write-only or unmapped address SHALL return 0, and reads SHALL never alter out_regs.
REQ-034 Back-to-back frames (ss_l high for >= 2 clk) SHALL each be decoded independently.

Reset
REQ-035 Asserting rst SHALL immediately force:
- state IDLE;
- out_regs, miso, miso_oe, wr_strobe and frame_err to 0;
- bit counter and shift registers to 0;
- synchronizer flops to ss_l=1, sclk=CPOL, mosi=0.
REQ-036 rst mid-frame SHALL abandon the frame without a write or frame_err; after release, the block SHALL wait for a fresh ss_l falling edge.

Structure
REQ-037 Package spi_reg_pkg SHALL hold the FSM state type and the command-field position constants (write-flag index, address width function).
REQ-038 Sub-module spi_sync (2-flop synchronizer with rise/fall detect outputs) SHALL be instantiated once per SPI input.

Verification
REQ-039 Mode 0, DATA_W=8: write frame 0x81,0xA5 -> out_regs[1]=0xA5; wr_strobe=2'b10 for 1 cycle; frame_err=0.
REQ-040 Mode 3: in_regs[0]=0x3C, read frame 0x02,0x00 -> miso shifts 0x3C MSB first; out_regs unchanged.
REQ-041 ss_l rises after 5 bits of the data word of write 0x80,0xFF -> frame_err pulses once; out_regs[0] stays 0.
REQ-042 Write to unmapped address 0xFF,0x12 -> no wr_strobe; a subsequent read of 0x7F returns 0x00.
REQ-043 rst asserted mid-DATA of write 0x80,0x55 -> all outputs 0 at once; the next full frame 0x80,0x55 sets out_regs[0]=0x55.
REQ-044 DATA_W=16, CPHA=1: two back-to-back frames write 0x8000,0xBEEF then read 0x0000 -> miso returns 0xBEEF.
